// File: rtl/alu_mc.sv
// Multi-cycle W-bit ALU: single-cycle logic/arith/compare ops, iterative shifts and shift-add multiply.
// Latency: 1 cycle for single-cycle and illegal ops and zero-distance shifts, 1+k for a shift by k, 1+W for mul.
// Backpressure: one op in flight; in_ready only in IDLE, result held in DONE until out_ready.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   in_valid/in_ready    request handshake; op, a, b are captured on accept
//   out_valid/out_ready  result handshake; res, car, of, zero, err are registered
module alu_mc #(
  parameter  int W  = 8,
  localparam int SW = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] res,
  output logic         car,
  output logic         of,
  output logic         zero,
  output logic         err
);

  localparam int CW = SW + 1;  // counter must hold the value W

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_NOT  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_EQ   = 4'd7;
  localparam logic [3:0] OP_SLTU = 4'd8;
  localparam logic [3:0] OP_SHL  = 4'd9;
  localparam logic [3:0] OP_SHR  = 4'd10;
  localparam logic [3:0] OP_SRA  = 4'd11;
  localparam logic [3:0] OP_MUL  = 4'd12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q;
  logic [3:0]     op_q;
  logic [CW-1:0]  cnt_q;
  logic [W-1:0]   work_q;   // shift operand, or remaining multiplier bits
  logic [2*W-1:0] mcand_q;  // multiplicand, shifted left each step
  logic [2*W-1:0] prod_q;   // partial product
  logic [W-1:0]   res_q;
  logic           car_q, of_q, zero_q, err_q;

  // single-cycle datapath, fed straight from the input operands at accept
  logic [W:0]     sum_w, dif_w;
  logic [W-1:0]   alu_res;
  logic           alu_car, alu_of, alu_err;
  logic [SW-1:0]  shamt;
  logic           is_shift, goes_busy;

  // one iteration of the multi-cycle datapath, fed from the working registers
  logic [W-1:0]   work_d;
  logic [2*W-1:0] mcand_d;
  logic [2*W-1:0] prod_d;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign res       = res_q;
  assign car       = car_q;
  assign of        = of_q;
  assign zero      = zero_q;
  assign err       = err_q;

  always_comb begin
    sum_w   = {1'b0, a} + {1'b0, b};
    // subtract as a + ~b + 1 so the carry reads as "no borrow"
    dif_w   = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
    shamt   = b[SW-1:0];
    alu_res = '0;
    alu_car = 1'b0;
    alu_of  = 1'b0;
    alu_err = 1'b0;
    case (op)
      OP_ADD: begin
        {alu_car, alu_res} = sum_w;
        alu_of = (a[W-1] == b[W-1]) && (sum_w[W-1] != a[W-1]);
      end
      OP_SUB: begin
        {alu_car, alu_res} = dif_w;
        alu_of = (a[W-1] != b[W-1]) && (dif_w[W-1] != a[W-1]);
      end
      OP_NOT:  alu_res = ~a;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLT:  alu_res = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_EQ:   alu_res = {{(W-1){1'b0}}, (a == b)};
      OP_SLTU: alu_res = {{(W-1){1'b0}}, (a < b)};
      // a shift only takes this path when the distance is zero
      OP_SHL, OP_SHR, OP_SRA: alu_res = a;
      OP_MUL:  alu_res = '0;
      default: alu_err = 1'b1;
    endcase
    is_shift  = (op == OP_SHL) || (op == OP_SHR) || (op == OP_SRA);
    goes_busy = (is_shift && (shamt != '0)) || (op == OP_MUL);
  end

  always_comb begin
    work_d  = work_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    case (op_q)
      OP_SHL: work_d = work_q << 1;
      OP_SHR: work_d = work_q >> 1;
      OP_SRA: work_d = {work_q[W-1], work_q[W-1:1]};
      OP_MUL: begin
        if (work_q[0]) prod_d = prod_q + mcand_q;
        mcand_d = mcand_q << 1;
        work_d  = work_q >> 1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      work_q  <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      res_q   <= '0;
      car_q   <= 1'b0;
      of_q    <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q <= op;
            if (goes_busy) begin
              state_q <= BUSY;
              if (op == OP_MUL) begin
                work_q  <= b;
                mcand_q <= {{W{1'b0}}, a};
                prod_q  <= '0;
                cnt_q   <= CW'(W);
              end else begin
                work_q  <= a;
                cnt_q   <= CW'(shamt);
              end
            end else begin
              state_q <= DONE;
              res_q   <= alu_res;
              car_q   <= alu_car;
              of_q    <= alu_of;
              zero_q  <= (alu_res == '0);
              err_q   <= alu_err;
            end
          end
        end
        BUSY: begin
          work_q  <= work_d;
          mcand_q <= mcand_d;
          prod_q  <= prod_d;
          cnt_q   <= cnt_q - CW'(1);
          // the step taken this cycle is the last one: publish it directly
          if (cnt_q == CW'(1)) begin
            state_q <= DONE;
            of_q    <= 1'b0;
            err_q   <= 1'b0;
            if (op_q == OP_MUL) begin
              res_q  <= prod_d[W-1:0];
              car_q  <= |prod_d[2*W-1:W];
              zero_q <= (prod_d[W-1:0] == '0);
            end else begin
              res_q  <= work_d;
              car_q  <= 1'b0;
              zero_q <= (work_d == '0);
            end
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised W-bit ALU with a valid/ready handshake on both sides and an FSM that handles single-cycle logic/arithmetic ops and multi-cycle iterative shift and multiply ops. It succeeds the team's 4-bit combinational ALU in the npc datapath labs, adding width generality, registered results, a zero flag, unsigned compare, shifts, multiply and illegal-opcode reporting. Upstream issues one operation at a time; downstream may apply backpressure.

## Interface
- W, default 8, operand/result width (W >= 2, power of two).
- SW, default $clog2(W), shift-amount width (derived, not overridden).
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept; high only in IDLE.
- op  input  4  opcode, sampled on accept.
- a, b  input  W  operands, sampled on accept.
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  downstream consumes result.
- res  output  W  result.
- car  output  1  carry out / multiply overflow.
- of  output  1  signed overflow.
- zero  output  1  res == 0.
- err  output  1  illegal opcode.

## Operation
- Accept: in_valid && in_ready at a rising edge; a, b, op latched internally; later input changes have no effect.
- Opcodes: 0 add, 1 sub, 2 not a, 3 and, 4 or, 5 xor, 6 slt (signed a<b -> 1 else 0), 7 eq (a==b -> 1 else 0), 8 sltu (unsigned a<b), 9 shl, 10 shr (logical), 11 sra, 12 mul (low W bits of unsigned product), 13-15 illegal.
- add: {car,res} = a+b (W+1 bits); of = (a[W-1]==b[W-1]) && (res[W-1]!=a[W-1]).
- sub: {car,res} = a + ~b + 1; car=1 means no borrow; of = (a[W-1]!=b[W-1]) && (res[W-1]!=a[W-1]).
- ops 2-8: car=0, of=0.
- Shifts: shamt = b[SW-1:0]; one bit position per BUSY cycle; sra replicates a[W-1]; car=0, of=0.
- mul: shift-add, one multiplier bit per BUSY cycle, exactly W BUSY cycles; car = 1 if upper W bits of full 2W product nonzero; of=0.
- Illegal: res=0, car=0, of=0, err=1; single-cycle path. err=0 for all legal ops.
- zero computed from final res for every op, including illegal (zero=1).
- FSM states: IDLE, BUSY, DONE.
  - IDLE -> DONE on accept of ops 0-8, 13-15, or shift with shamt=0.
  - IDLE -> BUSY on accept of shift with shamt>0 (counter=shamt) or mul (counter=W).
  - BUSY: one step per cycle, counter decrements; -> DONE on the cycle counter reaches 0 after the final step.
  - DONE -> IDLE when out_ready=1; otherwise hold.
- No accept in BUSY or DONE (in_ready=0); in_valid ignored there.

## Timing
- Reset (rst=1 at edge): state IDLE; in_ready=1, out_valid=0, res=0, car=0, of=0, zero=0, err=0; internal counter/accumulators cleared. Overrides any state, including mid-BUSY and DONE; an in-flight result is discarded, never emitted.
- Accept at edge N:
  - single-cycle op: out_valid=1 from N+1;
  - shift, shamt=k>0: out_valid from N+1+k;
  - mul: out_valid from N+1+W.
- res/car/of/zero/err registered, stable for the whole DONE interval regardless of out_ready or input activity; they hold last value after DONE->IDLE until the next result.
- Consume at edge M (out_valid && out_ready): out_valid=0, in_ready=1 from M+1; earliest next accept at M+1. Peak throughput one op per 2 cycles.
- rst and in_valid both high at one edge: reset wins, nothing accepted.

## Test plan
- Reset then add, W=8: a=0x7F, b=0x01, out_ready=1 -> out_valid at N+1, res=0x80, car=0, of=1, zero=0, err=0; in_ready back at N+2.
- Sub/compare: 0x00-0x01 -> res=0xFF, car=0, of=0; slt a=0xFF,b=0x01 -> res=1; sltu same operands -> res=0; eq 0x5A,0x5A -> res=1, zero=0.
- Shifts: shl a=0x81,b=0x03 -> out_valid exactly at N+4, res=0x08; sra a=0x80,b=0x07 -> res=0xFF at N+8; shr b=0x00 -> res=a at N+1.
- Multiply: a=0x10, b=0x11 -> out_valid at N+9, res=0x10, car=1; a=0x0F, b=0x0F -> res=0xE1, car=0.
- Backpressure/illegal: op=14 with out_ready=0 for 5 cycles -> out_valid held, res=0, zero=1, err=1, in_ready=0 throughout; in_valid pulses ignored; release out_ready -> IDLE next cycle.
- Reset mid-operation: assert rst at 3rd BUSY cycle of mul -> next cycle all outputs at reset values, no out_valid pulse; fresh add 0x01+0x02 then gives res=0x03 at N+1.
